mem_bus_responder: RTL and testbench

Multi-cycle data-memory responder: the target end of the processor's load/store path. It accepts byte/half/word read and write requests over a valid/ready handshake, services them from a byte-addressed little-endian array after a configurable number of wait states, and returns sign- or zero-extended load data with a response handshake. It replaces the single-cycle memory as the back end of the EX_MEM stage once the pipeline gains stall support.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_bus_responder.sv | 146 ++++++++++++++
 tb/tb_mem_bus_responder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the wait-state counter width.
package mem_bus_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;

    // Wide enough for the largest supported WAIT_STATES value (15)
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane gather/extend and misalignment detect for the memory responder.
// Optional macro MISALIGN_TRAP_EN turns misaligned/reserved accesses into faults.
module mem_lane_align
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic [1:0]             size,
    input  logic                   is_signed,
    input  logic [3:0][7:0]        rbytes,
    output logic [3:0][ADDR_W-1:0] lane_addr,
    output logic [3:0]             byte_en,
    output logic [31:0]            ld_data,
    output logic                   fault
);

    // Lane addresses wrap naturally at the ADDR_W boundary
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = addr + ADDR_W'(i);
        end
    end

    always_comb begin
        byte_en = 4'b1111;
        ld_data = {rbytes[3], rbytes[2], rbytes[1], rbytes[0]};
        case (size)
            SIZE_B: begin
                byte_en = 4'b0001;
                ld_data = is_signed ? {{24{rbytes[0][7]}}, rbytes[0]}
                                    : {24'h000000, rbytes[0]};
            end
            SIZE_H: begin
                byte_en = 4'b0011;
                ld_data = is_signed ? {{16{rbytes[1][7]}}, rbytes[1], rbytes[0]}
                                    : {16'h0000, rbytes[1], rbytes[0]};
            end
            default: begin
                byte_en = 4'b1111;
                ld_data = {rbytes[3], rbytes[2], rbytes[1], rbytes[0]};
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        fault = ((size == SIZE_H) && addr[0])
             || ((size == SIZE_W) && (addr[1:0] != 2'b00))
             || (size == SIZE_R);
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: rtl/mem_bus_responder.sv
// Multi-cycle byte-addressed data-memory responder with valid/ready request and
// response handshakes. Optional macro MISALIGN_TRAP_EN enables access faults.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    logic [7:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic                   do_access;
    logic [3:0][7:0]        rbytes;
    logic [3:0][ADDR_W-1:0] lane_addr;
    logic [3:0]             byte_en;
    logic [31:0]            ld_data;
    logic                   fault;

    mem_lane_align #(
        .ADDR_W(ADDR_W)
    ) u_align (
        .addr     (addr_q),
        .size     (size_q),
        .is_signed(signed_q),
        .rbytes   (rbytes),
        .lane_addr(lane_addr),
        .byte_en  (byte_en),
        .ld_data  (ld_data),
        .fault    (fault)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rbytes[i] = mem[lane_addr[i]];
        end
    end

    // Requests always pass through WAIT so response latency is WAIT_STATES+1
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        size_d    = size_q;
        signed_d  = signed_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d     = req_write;
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    wdata_d  = req_wdata;
                    cnt_d    = CNT_W'(WAIT_STATES);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    do_access = 1'b1;
                    rdata_d   = (wr_q || fault) ? 32'h0 : ld_data;
                    err_d     = fault;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            size_q   <= SIZE_B;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage has no reset; a store caught by reset is simply dropped
    always_ff @(posedge clk) begin
        if (rst && do_access && wr_q && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[lane_addr[i]] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder with WAIT_STATES of 1, 3 and 0.
// Expectations follow MISALIGN_TRAP_EN when the bench is built with it.
module tb_mem_bus_responder;
    import mem_bus_pkg::*;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;

    // index 0: WAIT_STATES=1, 1: WAIT_STATES=3, 2: WAIT_STATES=0
    logic        req_valid_v [3];
    logic        rsp_ready_v [3];
    logic        req_ready_v [3];
    logic        rsp_valid_v [3];
    logic        rsp_err_v   [3];
    logic [31:0] rsp_rdata_v [3];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mem_bus_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready_v[0]),
        .rsp_rdata(rsp_rdata_v[0]), .rsp_err(rsp_err_v[0])
    );

    mem_bus_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready_v[1]),
        .rsp_rdata(rsp_rdata_v[1]), .rsp_err(rsp_err_v[1])
    );

    mem_bus_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_v[2]), .rsp_ready(rsp_ready_v[2]),
        .rsp_rdata(rsp_rdata_v[2]), .rsp_err(rsp_err_v[2])
    );

    // Issue one request with rsp_ready held high; lat = edges from accept to rsp_valid (-1 on timeout)
    task automatic do_req(input int idx, input logic wr, input logic [7:0] addr,
                          input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        req_write   = wr;
        req_addr    = addr;
        req_size    = size;
        req_signed  = sgn;
        req_wdata   = wdata;
        req_valid_v[idx] = 1'b1;
        rsp_ready_v[idx] = 1'b1;
        @(posedge clk); #1;
        req_valid_v[idx] = 1'b0;
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rsp_valid_v[idx]) begin
                lat   = k;
                rdata = rsp_rdata_v[idx];
                err   = rsp_err_v[idx];
                break;
            end
        end
        @(posedge clk); #1;
        rsp_ready_v[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_ready_v[i] !== 1'b1) begin
                fails++; $display("[TB] FAIL reset_req_ready[%0d]: got %b, expected 1", i, req_ready_v[i]);
            end
            checks++;
            if (rsp_valid_v[i] !== 1'b0) begin
                fails++; $display("[TB] FAIL reset_rsp_valid[%0d]: got %b, expected 0", i, rsp_valid_v[i]);
            end
            checks++;
            if (rsp_rdata_v[i] !== 32'h0) begin
                fails++; $display("[TB] FAIL reset_rsp_rdata[%0d]: got %h, expected 0", i, rsp_rdata_v[i]);
            end
            checks++;
            if (rsp_err_v[i] !== 1'b0) begin
                fails++; $display("[TB] FAIL reset_rsp_err[%0d]: got %b, expected 0", i, rsp_err_v[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [7:0]  addrs [6] = '{8'h10, 8'h10, 8'h12, 8'h12, 8'h13, 8'h10};
        logic [1:0]  sizes [6] = '{SIZE_W, SIZE_B, SIZE_H, SIZE_H, SIZE_B, SIZE_W};
        logic        sgns  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [6] = '{32'h0, 32'hFFFF_FFF3, 32'h0000_8011, 32'hFFFF_8011,
                                   32'h0000_0080, 32'h8011_22F3};
        for (int v = 0; v < 6; v++) begin
            do_req(0, (v == 0), addrs[v], sizes[v], sgns[v], 32'h8011_22F3, rd, er, lat);
            checks++;
            if (rd !== exps[v] || er !== 1'b0) begin
                fails++; $display("[TB] FAIL store_load[%0d]: got %h err %b, expected %h err 0", v, rd, er, exps[v]);
            end
            checks++;
            if (lat != 2) begin
                fails++; $display("[TB] FAIL latency_ws1[%0d]: got %0d, expected 2", v, lat);
            end
        end
    endtask

    task automatic test_ws0();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(2, 1'b1, 8'h30, SIZE_H, 1'b0, 32'h0000_BEEF, rd, er, lat);
        checks++;
        if (lat != 1) begin
            fails++; $display("[TB] FAIL latency_ws0_store: got %0d, expected 1", lat);
        end
        do_req(2, 1'b0, 8'h30, SIZE_H, 1'b1, 32'h0, rd, er, lat);
        checks++;
        if (lat != 1 || rd !== 32'hFFFF_BEEF) begin
            fails++; $display("[TB] FAIL ws0_load: got lat %0d data %h, expected lat 1 data ffffbeef", lat, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        early;
        logic        bad;
        do_req(1, 1'b1, 8'h20, SIZE_W, 1'b0, 32'h1234_5678, rd, er, lat);
        checks++;
        if (lat != 4 || rd !== 32'h0 || er !== 1'b0) begin
            fails++; $display("[TB] FAIL ws3_store: got lat %0d data %h err %b, expected lat 4 data 0 err 0", lat, rd, er);
        end
        @(negedge clk);
        req_write = 1'b0; req_addr = 8'h20; req_size = SIZE_W; req_signed = 1'b0;
        req_valid_v[1] = 1'b1;
        rsp_ready_v[1] = 1'b0;
        @(posedge clk); #1;
        req_valid_v[1] = 1'b0;
        checks++;
        if (req_ready_v[1] !== 1'b0) begin
            fails++; $display("[TB] FAIL ws3_ready_after_accept: got %b, expected 0", req_ready_v[1]);
        end
        early = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            early = early | rsp_valid_v[1];
        end
        checks++;
        if (early !== 1'b0) begin
            fails++; $display("[TB] FAIL ws3_early_valid: got %b, expected 0", early);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid_v[1] !== 1'b1 || rsp_rdata_v[1] !== 32'h1234_5678) begin
            fails++; $display("[TB] FAIL ws3_valid_edge4: got valid %b data %h, expected 1 12345678", rsp_valid_v[1], rsp_rdata_v[1]);
        end
        // A competing store offered while the response is stalled must be ignored
        req_write = 1'b1; req_wdata = 32'hFFFF_FFFF;
        req_valid_v[1] = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (rsp_rdata_v[1] !== 32'h1234_5678 || req_ready_v[1] !== 1'b0 || rsp_valid_v[1] !== 1'b1)
                bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            fails++; $display("[TB] FAIL ws3_hold_stable: got unstable %b, expected 0", bad);
        end
        @(negedge clk);
        req_valid_v[1] = 1'b0;
        rsp_ready_v[1] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_v[1] = 1'b0;
        checks++;
        if (req_ready_v[1] !== 1'b1 || rsp_valid_v[1] !== 1'b0) begin
            fails++; $display("[TB] FAIL ws3_release: got ready %b valid %b, expected 1 0", req_ready_v[1], rsp_valid_v[1]);
        end
        do_req(1, 1'b0, 8'h20, SIZE_W, 1'b0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h1234_5678) begin
            fails++; $display("[TB] FAIL ws3_ignored_store: got %h, expected 12345678", rd);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [7:0]  baddr [4] = '{8'hFF, 8'h00, 8'h01, 8'h02};
        logic [7:0]  bexp  [4];
        bexp = TRAP ? '{8'h55, 8'h11, 8'h22, 8'h33} : '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        do_req(0, 1'b1, 8'h00, SIZE_W, 1'b0, 32'h4433_2211, rd, er, lat);
        do_req(0, 1'b1, 8'hFF, SIZE_B, 1'b0, 32'h0000_0055, rd, er, lat);
        do_req(0, 1'b1, 8'hFF, SIZE_W, 1'b0, 32'hAABB_CCDD, rd, er, lat);
        checks++;
        if (er !== TRAP || rd !== 32'h0 || lat != 2) begin
            fails++; $display("[TB] FAIL wrap_store: got err %b data %h lat %0d, expected err %b data 0 lat 2", er, rd, lat, TRAP);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b0, baddr[i], SIZE_B, 1'b0, 32'h0, rd, er, lat);
            checks++;
            if (rd !== {24'h0, bexp[i]}) begin
                fails++; $display("[TB] FAIL wrap_byte_%h: got %h, expected %h", baddr[i], rd, {24'h0, bexp[i]});
            end
        end
        do_req(0, 1'b0, 8'h00, SIZE_W, 1'b0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== (TRAP ? 32'h4433_2211 : 32'h44AA_BBCC)) begin
            fails++; $display("[TB] FAIL wrap_word0: got %h, expected %h", rd, TRAP ? 32'h4433_2211 : 32'h44AA_BBCC);
        end
        do_req(0, 1'b0, 8'hFF, SIZE_H, 1'b1, 32'h0, rd, er, lat);
        checks++;
        if (rd !== (TRAP ? 32'h0 : 32'hFFFF_CCDD) || er !== TRAP) begin
            fails++; $display("[TB] FAIL misaligned_half: got %h err %b, expected %h err %b", rd, er, TRAP ? 32'h0 : 32'hFFFF_CCDD, TRAP);
        end
        do_req(0, 1'b0, 8'h10, SIZE_R, 1'b0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== (TRAP ? 32'h0 : 32'h8011_22F3) || er !== TRAP) begin
            fails++; $display("[TB] FAIL reserved_size: got %h err %b, expected %h err %b", rd, er, TRAP ? 32'h0 : 32'h8011_22F3, TRAP);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        seen;
        do_req(0, 1'b1, 8'h40, SIZE_B, 1'b0, 32'h0000_005A, rd, er, lat);
        @(negedge clk);
        req_write = 1'b1; req_addr = 8'h40; req_size = SIZE_W; req_signed = 1'b0;
        req_wdata = 32'hDEAD_BEEF;
        req_valid_v[0] = 1'b1;
        rsp_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        req_valid_v[0] = 1'b0;
        rst = 1'b0;
        checks++;
        if (req_ready_v[0] !== 1'b0) begin
            fails++; $display("[TB] FAIL rst_wait_accepted: got ready %b, expected 0", req_ready_v[0]);
        end
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid_v[0];
        end
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid_v[0];
        end
        rsp_ready_v[0] = 1'b0;
        checks++;
        if (seen !== 1'b0 || req_ready_v[0] !== 1'b1) begin
            fails++; $display("[TB] FAIL rst_wait_idle: got valid_seen %b ready %b, expected 0 1", seen, req_ready_v[0]);
        end
        do_req(0, 1'b0, 8'h40, SIZE_B, 1'b0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_005A) begin
            fails++; $display("[TB] FAIL rst_wait_store_dropped: got %h, expected 0000005a", rd);
        end
    endtask

    initial begin
        rst = 1'b0;
        req_write = 1'b0; req_addr = '0; req_size = SIZE_B; req_signed = 1'b0; req_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            req_valid_v[i] = 1'b0;
            rsp_ready_v[i] = 1'b0;
        end
        test_reset();
        test_store_load();
        test_ws0();
        test_backpressure();
        test_wrap();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
